// File: rtl/flag_led_sequencer.sv
// flag_led_sequencer: steps an LED pattern every TICK_DIV rising edges of a timebase flag
module flag_led_sequencer #(
  parameter int LED_W    = 8,
  parameter int TICK_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flag,
  input  logic             en,
  input  logic [1:0]       mode,
  output logic [LED_W-1:0] led,
  output logic             step_pulse,
  output logic             wrap
);
  localparam int DW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [LED_W-1:0] ONE = LED_W'(1);
  localparam logic [LED_W-1:0] MSB = ONE << (LED_W - 1);
  typedef enum logic {PP_LEFT, PP_RIGHT} dir_t;
  dir_t dir_q, dir_d, pp_dir;
  logic [DW-1:0] div_q;
  logic [1:0] mode_q;
  logic flag_q, tick, step, wrap_d, blink_lo;
  logic [LED_W-1:0] led_d, shl, shr;
  assign tick = flag & ~flag_q;
  assign step = en & tick & (div_q == DW'(TICK_DIV - 1));
  assign shl = {led[LED_W-2:0], led[LED_W-1]};
  assign shr = {led[0], led[LED_W-1:1]};
  assign blink_lo = (mode_q == 2'b11) & (&led);
  // An end bit forces the bounce direction, so entering ping-pong at either end never shifts off
  assign pp_dir = led[LED_W-1] ? PP_RIGHT : led[0] ? PP_LEFT : dir_q;
  always_comb begin
    led_d = led;
    dir_d = dir_q;
    wrap_d = 1'b0;
    if (mode == 2'b11) begin
      led_d = blink_lo ? '0 : '1;
      wrap_d = blink_lo;
    end else if (mode_q == 2'b11) begin
      led_d = ONE;
      dir_d = PP_LEFT;
    end else if (mode == 2'b00) begin
      led_d = shl;
      wrap_d = shl == ONE;
    end else if (mode == 2'b01) begin
      led_d = shr;
      wrap_d = shr == MSB;
    end else begin
      led_d = pp_dir == PP_LEFT ? shl : shr;
      dir_d = led_d[LED_W-1] ? PP_RIGHT : led_d[0] ? PP_LEFT : pp_dir;
      wrap_d = (pp_dir == PP_RIGHT) & led_d[0];
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led <= ONE;
      step_pulse <= 1'b0;
      wrap <= 1'b0;
      div_q <= '0;
      dir_q <= PP_LEFT;
      mode_q <= 2'b00;
      flag_q <= 1'b1;
    end else begin
      flag_q <= flag;
      step_pulse <= step;
      wrap <= step & wrap_d;
      if (en & tick) div_q <= step ? '0 : div_q + 1'b1;
      if (step) begin
        led <= led_d;
        dir_q <= dir_d;
        mode_q <= mode;
      end
    end
  end
endmodule

// File: tb/tb_flag_led_sequencer.sv
// tb_flag_led_sequencer: directed and random stimulus against a position-based reference model
module tb_flag_led_sequencer;
  localparam int W = 8;
  localparam int D = 4;
  logic clk = 0, reset = 1, flag = 0, en = 0;
  logic [1:0] mode = 2'b00;
  logic [W-1:0] led;
  logic step_pulse, wrap;
  int compared = 0, mismatched = 0;

  flag_led_sequencer #(.LED_W(W), .TICK_DIV(D)) dut (
    .clk(clk), .reset(reset), .flag(flag), .en(en), .mode(mode),
    .led(led), .step_pulse(step_pulse), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // Reference model: lit position, tick count, direction, last sampled mode
  int m_pos, m_ticks;
  bit m_blink_on, m_right, m_flag_prev, m_step, m_wrap;
  logic [1:0] m_mode;

  function automatic logic [W-1:0] m_led();
    if (m_mode == 2'b11) return m_blink_on ? '1 : '0;
    return W'(1) << m_pos;
  endfunction

  function automatic void model_reset();
    m_pos = 0; m_ticks = 0; m_blink_on = 0; m_right = 0;
    m_flag_prev = 1; m_step = 0; m_wrap = 0; m_mode = 2'b00;
  endfunction

  function automatic void model_apply(input logic [1:0] md);
    m_wrap = 0;
    if (md == 2'b11) begin
      m_blink_on = (m_mode == 2'b11) ? !m_blink_on : 1'b1;
      m_wrap = !m_blink_on;
    end else if (m_mode == 2'b11) begin
      m_pos = 0; m_right = 0;
    end else if (md == 2'b00) begin
      m_pos = (m_pos + 1) % W; m_wrap = m_pos == 0;
    end else if (md == 2'b01) begin
      m_pos = (m_pos + W - 1) % W; m_wrap = m_pos == W - 1;
    end else begin
      if (m_pos == W - 1) m_right = 1;
      else if (m_pos == 0) m_right = 0;
      m_pos = m_right ? m_pos - 1 : m_pos + 1;
      m_wrap = m_pos == 0;
    end
    m_mode = md;
  endfunction

  function automatic void model_edge();
    bit t;
    t = flag && !m_flag_prev;
    m_flag_prev = flag;
    m_step = 0; m_wrap = 0;
    if (en && t) begin
      m_ticks++;
      if (m_ticks == D) begin
        m_ticks = 0; m_step = 1;
        model_apply(mode);
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic f, input logic e, input logic [1:0] md);
    @(negedge clk);
    flag = f; en = e; mode = md;
    @(posedge clk);
    model_edge();
    #1;
    chk("model_led", led, m_led());
    chk("model_step", step_pulse, m_step);
    chk("model_wrap", wrap, m_wrap);
  endtask

  task automatic pulse(input logic e, input logic [1:0] md);
    cyc(0, e, md);
    cyc(1, e, md);
  endtask

  task automatic step4(input logic [1:0] md);
    for (int i = 0; i < D; i++) pulse(1, md);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1;
    #1;
    chk("async_reset_led", led, 8'h01);
    chk("async_reset_step", step_pulse, 0);
    chk("async_reset_wrap", wrap, 0);
    model_reset();
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    int n;
    logic [W-1:0] e;
    model_reset();
    // T1: reset held while flag toggles
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      flag = ~flag;
      #1;
      chk("t1_reset_led", led, 8'h01);
      chk("t1_reset_step", step_pulse, 0);
    end
    @(negedge clk);
    flag = 1; en = 1; reset = 0;
    model_reset();
    cyc(1, 1, 2'b00);
    chk("t1_held_flag_no_step", step_pulse, 0);
    for (int i = 0; i < 3; i++) begin
      pulse(1, 2'b00);
      chk("t1_no_step_led", led, 8'h01);
      chk("t1_no_step", step_pulse, 0);
    end
    // T2: rotate-left
    pulse(1, 2'b00);
    chk("t2_first_step_led", led, 8'h02);
    chk("t2_first_step_pulse", step_pulse, 1);
    cyc(1, 1, 2'b00);
    chk("t2_pulse_one_cycle", step_pulse, 0);
    for (int s = 2; s <= 8; s++) begin
      step4(2'b00);
      e = 8'(1 << (s % 8));
      chk("t2_rotl_led", led, e);
      chk("t2_rotl_wrap", wrap, s == 8);
    end
    // T3: level flag is one tick
    for (int i = 0; i < 3; i++) pulse(1, 2'b00);
    cyc(0, 1, 2'b00);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1, 1, 2'b00);
      n += int'(step_pulse);
    end
    cyc(0, 1, 2'b00);
    chk("t3_level_one_step", n, 1);
    chk("t3_led", led, 8'h02);
    // T4: ping-pong
    do_reset();
    for (int i = 0; i < 14; i++) begin
      step4(2'b10);
      e = 8'(i < 7 ? 1 << (i + 1) : 1 << (13 - i));
      chk("t4_pp_led", led, e);
      chk("t4_pp_wrap", wrap, i == 13);
    end
    // T5: enable gating
    pulse(1, 2'b10);
    pulse(1, 2'b10);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      pulse(0, 2'b10);
      n += int'(step_pulse);
    end
    chk("t5_frozen_steps", n, 0);
    chk("t5_frozen_led", led, 8'h01);
    pulse(1, 2'b10);
    chk("t5_one_more_led", led, 8'h01);
    pulse(1, 2'b10);
    chk("t5_two_more_led", led, 8'h02);
    chk("t5_two_more_step", step_pulse, 1);
    // T6: blink, back to rotate, async reset mid-count
    do_reset();
    for (int i = 0; i < 4; i++) step4(2'b00);
    chk("t6_led10", led, 8'h10);
    step4(2'b11);
    chk("t6_blink_on", led, 8'hFF);
    chk("t6_blink_on_wrap", wrap, 0);
    step4(2'b11);
    chk("t6_blink_off", led, 8'h00);
    chk("t6_blink_off_wrap", wrap, 1);
    step4(2'b00);
    chk("t6_reload", led, 8'h01);
    pulse(1, 2'b00);
    pulse(1, 2'b00);
    do_reset();
    for (int i = 0; i < 3; i++) pulse(1, 2'b00);
    chk("t6_count_lost_led", led, 8'h01);
    pulse(1, 2'b00);
    chk("t6_count_lost_step", led, 8'h02);
    // Random phase
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      else cyc(1'($urandom_range(0, 1)), $urandom_range(0, 4) != 0,
               ($urandom_range(0, 19) == 0) ? 2'($urandom_range(0, 3)) : mode);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
